// File: rtl/reset_release.sv
// Per-channel soft-reset receiver: stretches each request to a minimum width, then holds it for a release delay.
// Status (busy/done/count/ctrl) is exposed on a byte-swapped CPU bus.
//   state    | meaning
//   S_IDLE   | channel released, rst_out low
//   S_ASSERT | request active or minimum width not yet met
//   S_HOLD   | request gone, counting the release delay
module reset_release #(
  parameter int N           = 9,
  parameter int MIN_CYCLES  = 16,
  parameter int HOLD_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  rst_out,
  input  logic [1:0]    a,
  input  logic [31:0]   d,
  input  logic          we,
  output logic [31:0]   spo,
  output logic          irq
);

  localparam int MAXC = (MIN_CYCLES > HOLD_CYCLES) ? MIN_CYCLES : HOLD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MIN_LAST  = CW'(MIN_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_HOLD} state_t;

  logic [N-1:0] w_fin;
  logic [N-1:0] w_busy;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_done_nxt;
  logic [N-1:0] r_done;
  logic [15:0]  r_evt;
  logic [15:0]  w_pop;
  logic         r_irq_en;
  logic         w_irq_en_nxt;
  logic [31:0]  w_wdata;
  logic [31:0]  w_rdata;
  logic         w_unused_wdata;

  assign w_wdata = {d[7:0], d[15:8], d[23:16], d[31:24]};
  assign w_unused_wdata = ^w_wdata[31:N];

  for (genvar g = 0; g < N; g++) begin : g_ch
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_rst;

    assign w_fin[g]   = (r_state == S_HOLD) && !req[g] && (r_cnt == HOLD_LAST);
    assign w_busy[g]  = (r_state != S_IDLE);
    assign rst_out[g] = r_rst;

    // Reset parks every channel in HOLD so all outputs release together after the hold delay.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_HOLD;
        r_cnt   <= '0;
        r_rst   <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (req[g]) begin
              r_state <= S_ASSERT;
              r_cnt   <= '0;
              r_rst   <= 1'b1;
            end
          end
          S_ASSERT: begin
            if (r_cnt == MIN_LAST && !req[g]) begin
              r_state <= S_HOLD;
              r_cnt   <= '0;
            end else if (r_cnt != MIN_LAST) begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_HOLD: begin
            if (req[g]) begin
              r_state <= S_ASSERT;
              r_cnt   <= '0;
            end else if (r_cnt == HOLD_LAST) begin
              r_state <= S_IDLE;
              r_rst   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rst   <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) w_pop = w_pop + {15'b0, w_fin[i]};
  end

  // A completion in the same cycle as a W1C clear of that bit leaves it set.
  assign w_clr        = (we && a == 2'd1) ? w_wdata[N-1:0] : '0;
  assign w_done_nxt   = (r_done & ~w_clr) | w_fin;
  assign w_irq_en_nxt = (we && a == 2'd3) ? w_wdata[0] : r_irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done   <= '0;
      r_evt    <= '0;
      r_irq_en <= 1'b0;
      irq      <= 1'b0;
    end else begin
      r_done   <= w_done_nxt;
      r_evt    <= r_evt + w_pop;
      r_irq_en <= w_irq_en_nxt;
      irq      <= w_irq_en_nxt & (|w_done_nxt);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (a)
      2'd0:    w_rdata[N-1:0] = w_busy;
      2'd1:    w_rdata[N-1:0] = r_done;
      2'd2:    w_rdata[15:0]  = r_evt;
      default: w_rdata[0]     = r_irq_en;
    endcase
  end

  assign spo = {w_rdata[7:0], w_rdata[15:8], w_rdata[23:16], w_rdata[31:24]};

endmodule

// File: tb/tb_reset_release.sv
// Bench for reset_release: directed scenarios plus random traffic against a timestamp-based channel model.
module tb_reset_release;
  localparam int N    = 9;
  localparam int MINC = 16;
  localparam int HOLD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  rst_out;
  logic [1:0]    a;
  logic [31:0]   d;
  logic          we;
  logic [31:0]   spo;
  logic          irq;

  reset_release #(.N(N), .MIN_CYCLES(MINC), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .rst_out(rst_out),
    .a(a), .d(d), .we(we), .spo(spo), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each channel remembers when its assert phase began (m_s) and when the
  // request finally dropped after the minimum width (m_e, -1 while still asserting).
  int           n_edge = 0;
  logic [N-1:0] m_busy;
  int           m_s [N];
  int           m_e [N];
  logic [N-1:0] m_done;
  logic [15:0]  m_evt;
  logic         m_irq_en;
  logic         m_irq;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b1;
      m_s[i]    = n_edge;
      m_e[i]    = n_edge;
    end
    m_done = '0; m_evt = '0; m_irq_en = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] fin;
    logic [31:0]  wd;
    if (!rst_n) begin
      model_reset();
      return;
    end
    n_edge++;
    fin = '0;
    for (int i = 0; i < N; i++) begin
      if (!m_busy[i]) begin
        if (req[i]) begin m_busy[i] = 1'b1; m_s[i] = n_edge; m_e[i] = -1; end
      end else if (m_e[i] < 0) begin
        if (!req[i] && n_edge >= m_s[i] + MINC) m_e[i] = n_edge;
      end else if (req[i]) begin
        m_s[i] = n_edge; m_e[i] = -1;
      end else if (n_edge == m_e[i] + HOLD) begin
        m_busy[i] = 1'b0; fin[i] = 1'b1;
      end
    end
    wd = swap32(d);
    if (we && a == 2'd1) m_done = m_done & ~wd[N-1:0];
    m_done = m_done | fin;
    m_evt  = m_evt + 16'($countones(fin));
    if (we && a == 2'd3) m_irq_en = wd[0];
    m_irq = m_irq_en && (|m_done);
  endtask

  function automatic logic [31:0] exp_spo(input logic [1:0] sel);
    logic [31:0] w;
    w = '0;
    case (sel)
      2'd0:    w[N-1:0] = m_busy;
      2'd1:    w[N-1:0] = m_done;
      2'd2:    w[15:0]  = m_evt;
      default: w[0]     = m_irq_en;
    endcase
    return swap32(w);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic check_cycle();
    cmp("rst_out", 32'(rst_out), 32'(m_busy));
    cmp("irq", 32'(irq), 32'(m_irq));
    cmp("spo", spo, exp_spo(a));
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [1:0] sel, input logic [31:0] internal);
    we = 1'b1; a = sel; d = swap32(internal);
    tick();
    we = 1'b0;
  endtask

  task automatic run_pulse(input int ch, input int len, output int h);
    int guard;
    h = 0;
    req[ch] = 1'b1;
    for (int j = 0; j < len; j++) begin
      tick();
      if (rst_out[ch]) h++;
    end
    req[ch] = 1'b0;
    guard = 0;
    while (rst_out[ch] && guard < 500) begin
      tick();
      if (rst_out[ch]) h++;
      guard++;
    end
  endtask

  initial begin
    int h;
    rst_n = 1'b0; req = '0; we = 1'b0; a = 2'd0; d = '0;
    @(posedge clk); model_edge(); #1;
    repeat (4) tick();
    rst_n = 1'b1;

    // Power-on release
    repeat (7) tick();
    cmp("por_hold_7", 32'(rst_out), 32'h1FF);
    tick();
    cmp("por_release_8", 32'(rst_out), 32'h0);
    a = 2'd1; #1;
    cmp("por_done", spo, 32'hFF010000);
    a = 2'd2; #1;
    cmp("por_count", spo, 32'h09000000);

    // Single 1-cycle pulse on channel 4
    bus_write(2'd1, 32'h1FF);
    a = 2'd0;
    run_pulse(4, 1, h);
    cmp("pulse_width", 32'(h), 32'd24);
    a = 2'd1; #1;
    cmp("pulse_done", spo, 32'h10000000);
    a = 2'd2; #1;
    cmp("pulse_count", spo, 32'h0A000000);

    // Long request on channel 0
    run_pulse(0, 40, h);
    cmp("long_width", 32'(h), 32'd48);

    // Retrigger 3 cycles into HOLD on channel 2
    req[2] = 1'b1; tick(); req[2] = 1'b0;
    h = rst_out[2] ? 1 : 0;
    repeat (18) begin tick(); if (rst_out[2]) h++; end
    req[2] = 1'b1; tick(); if (rst_out[2]) h++;
    req[2] = 1'b0;
    for (int g = 0; g < 500 && rst_out[2]; g++) begin tick(); if (rst_out[2]) h++; end
    cmp("retrig_width", 32'(h), 32'd43);
    a = 2'd2; #1;
    cmp("retrig_count", spo, 32'h0C000000);

    // W1C collision with completion of channel 4
    bus_write(2'd1, 32'h1FF);
    bus_write(2'd3, 32'h1);
    a = 2'd1;
    req[4] = 1'b1; tick(); req[4] = 1'b0;
    repeat (23) tick();
    bus_write(2'd1, 32'h10);
    a = 2'd1; #1;
    cmp("coll_rst_out4", 32'(rst_out[4]), 32'h0);
    cmp("coll_done", spo, 32'h10000000);
    cmp("coll_irq", 32'(irq), 32'h1);
    bus_write(2'd1, 32'h10);
    a = 2'd1; #1;
    cmp("clear_done", spo, 32'h0);
    cmp("clear_irq", 32'(irq), 32'h0);

    // Counter wrap with three simultaneous completions
    a = 2'd2;
    force dut.r_evt = 16'hFFFE;
    m_evt = 16'hFFFE;
    tick();
    release dut.r_evt;
    req = 9'h122; tick(); req = '0;
    repeat (30) tick();
    a = 2'd2; #1;
    cmp("wrap_count", spo, 32'h01000000);
    cmp("wrap_rst_out", 32'(rst_out), 32'h0);

    // Random traffic, with one mid-run reset
    for (int it = 0; it < 3000; it++) begin
      for (int i = 0; i < N; i++)
        req[i] = ($urandom_range(0, 99) < (req[i] ? 85 : 3));
      we = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (it == 1500) begin
        we = 1'b0;
        rst_n = 1'b0; model_reset();
        tick(); tick();
        rst_n = 1'b1;
      end
      tick();
    end
    req = '0; we = 1'b0;
    repeat (60) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
